// File: rtl/cntbank_pkg.sv
// cntbank_pkg: shared types and helpers for the windowed counter bank.
// Build option: CNTBANK_SAT_EN selects saturating counters (default wraps).
package cntbank_pkg;

   // Count width shared with the Sobol RNG comparators feeding this block.
   localparam int unsigned SOBOLRNG_BITWIDTH = 8;
   localparam int unsigned DEF_BITWIDTH      = SOBOLRNG_BITWIDTH;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Window counter width: clog2 of the window length, never below one bit.
   function automatic int unsigned win_width(input int unsigned winlen);
      return (winlen <= 1) ? 1 : $clog2(winlen);
   endfunction

endpackage

// File: rtl/cntbank_cntchan.sv
// cntchan: single-channel bitstream counter with clear and sticky overflow.
// Build option: CNTBANK_SAT_EN clamps at full scale; otherwise the count wraps.
module cntchan
   import cntbank_pkg::*;
#(
   parameter int unsigned BITWIDTH = DEF_BITWIDTH
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic                inc_i,
   output logic [BITWIDTH-1:0] cnt_o,
   output logic [BITWIDTH-1:0] upd_cnt_c,
   output logic                upd_ovf_c
);

   localparam logic [BITWIDTH-1:0] CNT_MAX = '1;

   logic [BITWIDTH-1:0] cnt_q, cnt_d;
   logic                ovf_q, ovf_d;

   // Post-increment value (before any clear), plus next state with clear applied.
   always_comb begin
      upd_cnt_c = cnt_q;
      upd_ovf_c = ovf_q;
      if (inc_i) begin
         if (cnt_q == CNT_MAX) begin
            upd_ovf_c = 1'b1;
`ifdef CNTBANK_SAT_EN
            upd_cnt_c = CNT_MAX;
`else
            upd_cnt_c = '0;
`endif
         end else begin
            upd_cnt_c = cnt_q + BITWIDTH'(1);
         end
      end
      cnt_d = clr_i ? '0   : upd_cnt_c;
      ovf_d = clr_i ? 1'b0 : upd_ovf_c;
   end

   // Count and sticky overflow registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cntbank.sv
// cntbank: NUM_CH bitstream counters sampled over a WINLEN-cycle window,
// with latched results, overflow flags and a one-cycle valid pulse.
// Build option: CNTBANK_SAT_EN (saturating counters); default build wraps.
module cntbank
   import cntbank_pkg::*;
#(
   parameter int unsigned BITWIDTH = DEF_BITWIDTH,
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned WINLEN   = 256
) (
   input  logic                       iClk,
   input  logic                       iRst,
   input  logic                       iStart,
   input  logic [NUM_CH-1:0]          iEn,
   output logic                       oBusy,
   output logic [NUM_CH*BITWIDTH-1:0] oCnt,
   output logic [NUM_CH*BITWIDTH-1:0] oResult,
   output logic [NUM_CH-1:0]          oOvf,
   output logic                       oValid
);

   localparam int unsigned     WW    = win_width(WINLEN);
   localparam logic [WW-1:0]   WLAST = WW'(WINLEN - 1);

   state_e                     state_q, state_d;
   logic [WW-1:0]              wcnt_q, wcnt_d;
   logic [NUM_CH*BITWIDTH-1:0] res_q, res_d;
   logic [NUM_CH-1:0]          rovf_q, rovf_d;
   logic                       valid_q, valid_d;

   logic                       run_c, last_c, clr_c;
   logic [NUM_CH*BITWIDTH-1:0] upd_cnt_c;
   logic [NUM_CH-1:0]          upd_ovf_c;

   assign run_c  = (state_q == RUN);
   assign last_c = run_c && (wcnt_q == WLAST);
   // A new window starts from idle or directly out of the last window cycle.
   assign clr_c  = iStart && (!run_c || last_c);

   // Per-channel counters; increments only count while the window is open.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      cntchan #(
         .BITWIDTH (BITWIDTH)
      ) u_chan (
         .clk_i     (iClk),
         .rst_i     (iRst),
         .clr_i     (clr_c),
         .inc_i     (run_c && iEn[k]),
         .cnt_o     (oCnt[k*BITWIDTH +: BITWIDTH]),
         .upd_cnt_c (upd_cnt_c[k*BITWIDTH +: BITWIDTH]),
         .upd_ovf_c (upd_ovf_c[k])
      );
   end

   // Next-state logic: window sequencing and result capture.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      res_d   = res_q;
      rovf_d  = rovf_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (iStart) begin
               state_d = RUN;
               wcnt_d  = '0;
            end
         end
         RUN: begin
            wcnt_d = wcnt_q + WW'(1);
            if (last_c) begin
               res_d   = upd_cnt_c;
               rovf_d  = upd_ovf_c;
               valid_d = 1'b1;
               wcnt_d  = '0;
               if (!iStart) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, window counter and result registers.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         res_q   <= '0;
         rovf_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         res_q   <= res_d;
         rovf_q  <= rovf_d;
         valid_q <= valid_d;
      end
   end

   assign oBusy   = run_c;
   assign oResult = res_q;
   assign oOvf    = rovf_q;
   assign oValid  = valid_q;

endmodule

// File: tb/tb_cntbank.sv
// tb_cntbank: random and directed stimulus against a window-sum reference model.
// Honours CNTBANK_SAT_EN the same way as the RTL build.
module tb_cntbank;

   localparam int NCH = 4;
   localparam int BW0 = 4;
   localparam int WL0 = 16;
   localparam int BW1 = 8;
   localparam int WL1 = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;
   logic [NCH-1:0] en0 = '0, en1 = '0;

   logic              busy0, valid0, busy1, valid1;
   logic [NCH*BW0-1:0] cnt0, res0;
   logic [NCH*BW1-1:0] cnt1, res1;
   logic [NCH-1:0]    ovf0, ovf1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: integer sums per window and samples still to take.
   bit       act[2];
   int       rem[2];
   int       sum[2][NCH];
   logic [31:0] eres[2];
   logic [NCH-1:0] eovf[2];
   bit       evld[2];

   always #5 clk = ~clk;

   cntbank #(.BITWIDTH(BW0), .NUM_CH(NCH), .WINLEN(WL0)) u_dut0 (
      .iClk(clk), .iRst(rst), .iStart(start0), .iEn(en0),
      .oBusy(busy0), .oCnt(cnt0), .oResult(res0), .oOvf(ovf0), .oValid(valid0)
   );

   cntbank #(.BITWIDTH(BW1), .NUM_CH(NCH), .WINLEN(WL1)) u_dut1 (
      .iClk(clk), .iRst(rst), .iStart(start1), .iEn(en1),
      .oBusy(busy1), .oCnt(cnt1), .oResult(res1), .oOvf(ovf1), .oValid(valid1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int bw_of(input int i);
      return (i == 0) ? BW0 : BW1;
   endfunction

   function automatic int wl_of(input int i);
      return (i == 0) ? WL0 : WL1;
   endfunction

   // Visible counter value for an integer number of increments.
   function automatic logic [31:0] fold(input int s, input int bw);
      int mx;
      mx = (1 << bw) - 1;
`ifdef CNTBANK_SAT_EN
      return 32'((s > mx) ? mx : s);
`else
      return 32'(s % (mx + 1));
`endif
   endfunction

   function automatic logic [31:0] exp_cnt(input int i);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < NCH; k++) v = v | (fold(sum[i][k], bw_of(i)) << (k * bw_of(i)));
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         act[i] = 0; rem[i] = 0; eres[i] = '0; eovf[i] = '0; evld[i] = 0;
         for (int k = 0; k < NCH; k++) sum[i][k] = 0;
      end
   endtask

   task automatic model_step(input int i, input logic st, input logic [NCH-1:0] en);
      evld[i] = 0;
      if (!act[i]) begin
         if (st) begin
            act[i] = 1;
            rem[i] = wl_of(i);
            for (int k = 0; k < NCH; k++) sum[i][k] = 0;
         end
      end else begin
         for (int k = 0; k < NCH; k++) sum[i][k] = sum[i][k] + int'(en[k]);
         rem[i] = rem[i] - 1;
         if (rem[i] == 0) begin
            eres[i] = exp_cnt(i);
            for (int k = 0; k < NCH; k++) eovf[i][k] = (sum[i][k] > (1 << bw_of(i)) - 1);
            evld[i] = 1;
            if (st) begin
               rem[i] = wl_of(i);
               for (int k = 0; k < NCH; k++) sum[i][k] = 0;
            end else begin
               act[i] = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("busy0",  64'(busy0),  64'(act[0]));
      chk("cnt0",   64'(cnt0),   64'(exp_cnt(0)));
      chk("res0",   64'(res0),   64'(eres[0]));
      chk("ovf0",   64'(ovf0),   64'(eovf[0]));
      chk("valid0", 64'(valid0), 64'(evld[0]));
      chk("busy1",  64'(busy1),  64'(act[1]));
      chk("cnt1",   64'(cnt1),   64'(exp_cnt(1)));
      chk("res1",   64'(res1),   64'(eres[1]));
      chk("ovf1",   64'(ovf1),   64'(eovf[1]));
      chk("valid1", 64'(valid1), 64'(evld[1]));
   endtask

   // One clock: drive at negedge, model at posedge, check at next negedge.
   task automatic cycle(input logic s0, input logic [NCH-1:0] e0);
      start0 = s0;
      en0    = e0;
      start1 = ($urandom_range(0, 2) == 0);
      en1    = NCH'($urandom);
      @(posedge clk);
      model_step(0, start0, en0);
      model_step(1, start1, en1);
      @(negedge clk);
      check_all();
   endtask

   // Asynchronous reset from mid-cycle; outputs must clear before any edge.
   task automatic do_reset();
      #1 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      check_all();
      rst = 1'b0;

      // Constant 0101 over a full window: channels 0/2 overflow.
      cycle(1'b1, 4'b0000);
      for (int c = 0; c < WL0; c++) cycle(1'b0, 4'b0101);
      for (int c = 0; c < 3; c++) cycle(1'b0, 4'b1111);

      // Toggling channel 0: eight increments, no overflow.
      cycle(1'b1, 4'b0000);
      for (int c = 0; c < WL0; c++) cycle(1'b0, (c % 2 == 0) ? 4'b0001 : 4'b0000);
      for (int c = 0; c < 3; c++) cycle(1'b0, 4'b0000);

      // Start held high: back-to-back windows.
      for (int c = 0; c < 3 * WL0 + 1; c++) cycle(1'b1, NCH'($urandom));
      cycle(1'b0, 4'b0000);
      cycle(1'b0, 4'b0000);

      // Reset at window count 7, then a fresh window of all ones.
      cycle(1'b1, 4'b0000);
      for (int c = 0; c < 7; c++) cycle(1'b0, 4'b1111);
      do_reset();
      cycle(1'b1, 4'b0000);
      for (int c = 0; c < WL0 + 2; c++) cycle(1'b0, 4'b1111);

      // Start mid-window is ignored.
      cycle(1'b1, 4'b0000);
      for (int c = 0; c < WL0 + 2; c++) cycle(c == 5, 4'b0010);

      // Random traffic with occasional resets.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         else cycle($urandom_range(0, 7) == 0, NCH'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
